// File: rtl/jk_excite_pkg.sv
// JK excitation helpers: per-bit {J,K} drive codes and the table that maps a present/next state to them.
// Latency: combinational only; no state lives in this package.
// Backpressure: not applicable.
package jk_excite_pkg;

    // {J,K} drive codes as seen by a JK flip-flop
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Excitation for one bit moving from q to t. Where J or K is a don't-care,
    // dc fills it: dc=0 yields hold/set/reset codes, dc=1 yields the toggle form.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
        logic [1:0] code;
        case ({q, t})
            2'b00:   code = dc ? JK_RST : JK_HOLD;
            2'b01:   code = dc ? JK_TGL : JK_SET;
            2'b10:   code = dc ? JK_TGL : JK_RST;
            default: code = dc ? JK_SET : JK_HOLD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jk_excite_driver_if.sv
// Target-word stream from the pattern source into the JK drive block.
// Latency: wires only; a word transfers on any edge where in_valid and in_ready are both high.
// Backpressure: the receiver drops in_ready while its target FIFO is full.
interface jk_excite_driver_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_target;

    modport master (output in_valid, output in_target, input in_ready);
    modport slave  (input in_valid, input in_target, output in_ready);
endinterface

// File: rtl/jk_target_fifo.sv
// Synchronous target FIFO, WIDTH x DEPTH, with a registered occupancy count.
// Latency: a pushed word can be popped on the next edge; pop_dat is the current head, not registered.
// Backpressure: a push is ignored while full and a pop is ignored while empty.
module jk_target_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a WIDTH-bit external JK bank one target per step and checks its Q readback for misses.
// Latency: j/k registered on the pop edge; the bank moves one edge later; a miss is flagged two edges after the pop.
// Backpressure: in_ready = FIFO not full; pops wait for step_en and are held while a resync is pending.
module jk_excite_driver
    import jk_excite_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int DC_VAL = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    jk_excite_driver_if.slave       in_if,
    input  logic                    step_en,
    input  logic                    resync,
    input  logic                    clr_err,
    input  logic [WIDTH-1:0]        q_fb,
    output logic [WIDTH-1:0]        j,
    output logic [WIDTH-1:0]        k,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    busy,
    output logic                    mismatch,
    output logic [WIDTH-1:0]        err_bits
);
    localparam logic       DC_BIT     = (DC_VAL != 0);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic             fifo_full, fifo_empty;
    logic [WIDTH-1:0] fifo_dat;
    logic             push, pop, drained;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s1_t_q, s1_t_d, s2_t_q, s2_t_d;
    logic             mismatch_q, mismatch_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [WIDTH-1:0] exc_j, exc_k;
    logic [1:0]       jk_bit;
    logic             fail;
    logic [WIDTH-1:0] diff;

    assign in_if.in_ready = ~fifo_full;
    assign push    = in_if.in_valid & ~fifo_full;
    // A resync request blocks the pop on its own edge as well as while pending
    assign pop     = step_en & ~fifo_empty & (state_q == ST_IDLE) & ~resync;
    assign drained = ~s1_vld_q & ~s2_vld_q;

    jk_target_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (in_if.in_target),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    // Per-bit J/K from the last commanded target to the FIFO head; q_fb lags a cycle so it is not used here
    always_comb begin
        exc_j  = '0;
        exc_k  = '0;
        jk_bit = JK_HOLD;
        for (int i = 0; i < WIDTH; i++) begin
            jk_bit   = jk_excite(exp_q[i], fifo_dat[i], DC_BIT);
            exc_j[i] = jk_bit[1];
            exc_k[i] = jk_bit[0];
        end
    end

    // Drive, expected-state, check pipeline and resync sequencing
    always_comb begin
        j_d      = pop ? exc_j : '0;
        k_d      = pop ? exc_k : '0;
        s1_vld_d = pop;
        s1_t_d   = fifo_dat;
        s2_vld_d = s1_vld_q;
        s2_t_d   = s1_t_q;
        exp_d    = exp_q;
        state_d  = state_q;
        if (pop) begin
            exp_d = fifo_dat;
        end
        case (state_q)
            ST_IDLE: begin
                if (resync) begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                if (drained) begin
                    exp_d   = q_fb;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Sticky miss flags; a miss on the same edge as clr_err survives the clear
    always_comb begin
        fail = s2_vld_q & (q_fb != s2_t_q);
        diff = fail ? (q_fb ^ s2_t_q) : '0;
        if (clr_err) begin
            mismatch_d = fail;
            err_d      = diff;
        end else begin
            mismatch_d = mismatch_q | fail;
            err_d      = err_q | diff;
        end
    end

    // State registers; reset wins over any in-flight step or pending resync
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            exp_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            s1_vld_q   <= 1'b0;
            s1_t_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_t_q     <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            j_q        <= j_d;
            k_q        <= k_d;
            s1_vld_q   <= s1_vld_d;
            s1_t_q     <= s1_t_d;
            s2_vld_q   <= s2_vld_d;
            s2_t_q     <= s2_t_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign mismatch = mismatch_q;
    assign err_bits = err_q;
    assign busy     = ~fifo_empty | s1_vld_q | s2_vld_q | (state_q == ST_PENDING);

endmodule
